pipe_adder: RTL and testbench
=============================

# pipe_adder

Parametrised, pipelined ripple-carry adder with a valid/ready handshake. It generalises the combinational half/full adder cells to WIDTH-bit operands by splitting the carry chain into SEG-bit segments, one segment per pipeline stage. It sustains one addition per clock under backpressure. It sits in the arithmetic library as the registered adder used by datapath blocks too wide for a single-cycle carry chain.

## Interface
- WIDTH, 16, operand and sum width in bits; must be a multiple of SEG.
- SEG, 4, bits resolved per pipeline stage; STAGES = WIDTH/SEG, must be ≥ 1.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- in_valid  in  1  a, b, cin valid this cycle.
- in_ready  out  1  adder accepts input this cycle.
- a  in  WIDTH  operand A, unsigned or two's complement.
- b  in  WIDTH  operand B.
- cin  in  1  carry into bit 0.
- out_valid  out  1  sum/cout hold a result.
- out_ready  in  1  consumer accepts the result this cycle.
- sum  out  WIDTH  (a + b + cin) mod 2^WIDTH.
- cout  out  1  carry out of bit WIDTH-1.
- ovf  out  1  signed overflow; present only with PIPE_ADDER_OVF_EN.

## Operation
- Stage k (0..STAGES-1) adds segment bits [k*SEG +: SEG] of the delayed operands plus the carry registered by stage k-1. Stage 0 uses cin.
- Each stage registers:
  - the sum segments completed so far,
  - its carry-out,
  - the not-yet-added operand segments,
  - a valid bit.
- Handshakes:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Global stall: stall = out_valid && !out_ready. While stalled, every stage register holds, including bubbles, and in_ready = 0.
- in_ready = !stall; this is combinational from out_valid/out_ready only.
- When not stalled, every stage advances one position each cycle. A bubble (valid 0) enters when !in_valid.
- Results leave in acceptance order. There is no reordering and no drop.
- Operands presented while in_ready = 0 are ignored; the source must hold them.
- Reset: when rst_n = 0 at a rising edge, every stage valid bit clears and all data registers clear.
  - out_valid = 0, sum = 0, cout = 0, ovf = 0 the cycle after reset.
  - in_ready = 1 while out_valid = 0.
  - In-flight operations are discarded, never emitted.
  - Reset takes priority over stall and input transfer.
- Arithmetic: no width growth. The carry beyond bit WIDTH-1 goes to cout only; sum wraps modulo 2^WIDTH.
- STAGES = 1: degenerates to a single registered adder with the same handshake.

## Timing
- Latency: a result accepted at edge N is out_valid after edge N+STAGES, absent stalls.
- Each stall cycle adds exactly one cycle of latency to every in-flight operation.
- Throughput: one result per cycle while out_ready = 1.
- out_valid, sum, cout and ovf are registered outputs.
- in_ready is the only combinational output.
- sum, cout and ovf stay stable while out_valid && !out_ready.

## Configuration
- PIPE_ADDER_OVF_EN defined:
  - port ovf exists, registered alongside cout;
  - ovf = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]), using sign bits carried down the pipeline;
  - ovf resets to 0.
- PIPE_ADDER_OVF_EN undefined:
  - port ovf and its sign-tracking registers are absent;
  - all other behaviour is identical.

## Test plan
All scenarios use WIDTH=16, SEG=4.
- Reset: hold rst_n=0 for 2 cycles with in_valid=1, then release.
  - out_valid=0, sum=0, cout=0 during reset and the following cycle.
  - The first result appears 4 cycles after the first accepted input.
- Carry across segments: a=0x00FF, b=0x0001, cin=0, out_ready=1.
  - After 4 cycles: sum=0x0100, cout=0.
  - Then a=0xFFFF, b=0x0000, cin=1 gives sum=0x0000, cout=1.
- Throughput: 8 back-to-back inputs a=i, b=0x1000*i for i=0..7, with out_ready=1.
  - out_valid is high for 8 consecutive cycles starting 4 cycles after the first input.
  - Sums arrive in order.
- Backpressure: stream 6 operations and drop out_ready for 3 cycles mid-stream.
  - in_ready=0 exactly during those stall cycles.
  - sum is held stable.
  - No result is lost or duplicated; total latency grows by 3 cycles.
- Reset mid-flight: assert rst_n=0 for one cycle with 3 operations in flight.
  - None of the 3 is ever emitted.
  - The next accepted operation returns a correct sum after 4 cycles.
- Overflow (PIPE_ADDER_OVF_EN):
  - 0x7FFF+0x0001 gives sum=0x8000, ovf=1, cout=0.
  - 0xFFFF+0x0001 gives ovf=0, cout=1.

Source files
------------

// File: rtl/pipe_adder_if.sv
// Handshake bundle for pipe_adder: operand channel (a, b, cin) in, result channel (sum, cout) out.
// The ovf signal exists only when PIPE_ADDER_OVF_EN is defined.
interface pipe_adder_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef PIPE_ADDER_OVF_EN
    logic             ovf;

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
`else
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );
`endif
endinterface

// File: rtl/pipe_adder.sv
// Pipelined ripple-carry adder: one SEG-bit carry segment per stage, global stall on output backpressure.
// Optional signed-overflow output enabled by defining PIPE_ADDER_OVF_EN.
module pipe_adder #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    pipe_adder_if.slave bus
);
    localparam int STAGES = WIDTH / SEG;
    localparam int SW     = SEG + 1;

    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] carry_q, carry_d;
    logic [WIDTH-1:0]  word_q [STAGES];
    logic [WIDTH-1:0]  word_d [STAGES];
    logic [WIDTH-1:0]  brem_q [STAGES];
    logic [WIDTH-1:0]  brem_d [STAGES];

    logic              src_valid [STAGES];
    logic              src_carry [STAGES];
    logic [WIDTH-1:0]  src_word  [STAGES];
    logic [WIDTH-1:0]  src_b     [STAGES];

    logic [SEG:0]      seg_sum;
    logic              stall;

`ifdef PIPE_ADDER_OVF_EN
    logic              sa_q [STAGES];
    logic              sa_d [STAGES];
    logic              sb_q [STAGES];
    logic              sb_d [STAGES];
    logic              src_sa [STAGES];
    logic              src_sb [STAGES];
    logic              ovf_q, ovf_d;
`endif

    // word holds finished sum segments in its top bits and unconsumed operand-A bits below;
    // it shifts right by SEG per stage, so after the last stage it is exactly the sum.
    assign src_valid[0] = bus.in_valid;
    assign src_carry[0] = bus.cin;
    assign src_word[0]  = bus.a;
    assign src_b[0]     = bus.b;
`ifdef PIPE_ADDER_OVF_EN
    assign src_sa[0]    = bus.a[WIDTH-1];
    assign src_sb[0]    = bus.b[WIDTH-1];
`endif

    for (genvar k = 1; k < STAGES; k++) begin : g_link
        assign src_valid[k] = valid_q[k-1];
        assign src_carry[k] = carry_q[k-1];
        assign src_word[k]  = word_q[k-1];
        assign src_b[k]     = brem_q[k-1];
`ifdef PIPE_ADDER_OVF_EN
        assign src_sa[k]    = sa_q[k-1];
        assign src_sb[k]    = sb_q[k-1];
`endif
    end

    assign stall = valid_q[STAGES-1] && !bus.out_ready;

    always_comb begin
        seg_sum = '0;
        valid_d = '0;
        carry_d = '0;
        for (int k = 0; k < STAGES; k++) begin
            word_d[k] = '0;
            brem_d[k] = '0;
        end
`ifdef PIPE_ADDER_OVF_EN
        ovf_d = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            sa_d[k] = 1'b0;
            sb_d[k] = 1'b0;
        end
`endif
        for (int k = 0; k < STAGES; k++) begin
            seg_sum    = {1'b0, src_word[k][SEG-1:0]} + {1'b0, src_b[k][SEG-1:0]} + SW'(src_carry[k]);
            valid_d[k] = src_valid[k];
            carry_d[k] = seg_sum[SEG];
            word_d[k]  = (src_word[k] >> SEG) | (WIDTH'(seg_sum[SEG-1:0]) << (WIDTH - SEG));
            brem_d[k]  = src_b[k] >> SEG;
`ifdef PIPE_ADDER_OVF_EN
            sa_d[k]    = src_sa[k];
            sb_d[k]    = src_sb[k];
`endif
        end
`ifdef PIPE_ADDER_OVF_EN
        ovf_d = (src_sa[STAGES-1] == src_sb[STAGES-1]) &&
                (word_d[STAGES-1][WIDTH-1] != src_sa[STAGES-1]);
`endif
    end

    // A stall freezes every stage, bubbles included, so in-flight spacing is preserved.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            carry_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                word_q[k] <= '0;
                brem_q[k] <= '0;
            end
`ifdef PIPE_ADDER_OVF_EN
            ovf_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                sa_q[k] <= 1'b0;
                sb_q[k] <= 1'b0;
            end
`endif
        end else if (!stall) begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            for (int k = 0; k < STAGES; k++) begin
                word_q[k] <= word_d[k];
                brem_q[k] <= brem_d[k];
            end
`ifdef PIPE_ADDER_OVF_EN
            ovf_q <= ovf_d;
            for (int k = 0; k < STAGES; k++) begin
                sa_q[k] <= sa_d[k];
                sb_q[k] <= sb_d[k];
            end
`endif
        end
    end

    assign bus.in_ready  = !stall;
    assign bus.out_valid = valid_q[STAGES-1];
    assign bus.sum       = word_q[STAGES-1];
    assign bus.cout      = carry_q[STAGES-1];
`ifdef PIPE_ADDER_OVF_EN
    assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder (WIDTH=16, SEG=4): directed vectors with hand-computed results,
// a separate monitor compares every output transfer, including latency, against the queue.
module tb_pipe_adder;
    localparam int WIDTH = 16;
    localparam int SEG   = 4;
    localparam int LAT   = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pipe_adder_if #(.WIDTH(WIDTH)) bus ();

    pipe_adder #(.WIDTH(WIDTH), .SEG(SEG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          win;
        int          stalls;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int cyc          = 0;
    int stall_cnt    = 0;
    int errors       = 0;
    int checks       = 0;
    int out_count    = 0;
    int last_out_win = 0;

    // Window counter and count of windows in which the bench withheld out_ready.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.out_ready === 1'b0) stall_cnt <= stall_cnt + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (window %0d)", name, act, exp, cyc);
        end
    endtask

    // Present one operation and hold it until accepted; push its expected result on acceptance.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic cin,
                                 input logic [15:0] exp_sum, input logic exp_cout, input logic exp_ovf);
        exp_t item;
        bit   accepted;
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        accepted     = 1'b0;
        for (int t = 0; t < 40 && !accepted; t++) begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus.in_ready === 1'b1) begin
                item.sum    = exp_sum;
                item.cout   = exp_cout;
                item.ovf    = exp_ovf;
                item.win    = cyc;
                item.stalls = stall_cnt;
                sb.push_back(item);
                accepted = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!accepted) checkOutput("accept_timeout", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every output transfer must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_output", 32'(bus.out_valid), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("sum", 32'(bus.sum), 32'(mon_e.sum));
                checkOutput("cout", 32'(bus.cout), 32'(mon_e.cout));
`ifdef PIPE_ADDER_OVF_EN
                checkOutput("ovf", 32'(bus.ovf), 32'(mon_e.ovf));
`endif
                checkOutput("latency", 32'(cyc - mon_e.win), 32'(LAT + stall_cnt - mon_e.stalls));
                out_count++;
                last_out_win = cyc;
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before 100000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

    logic [15:0] tp_sum [8] = '{16'h0000, 16'h1001, 16'h2002, 16'h3003,
                                16'h4004, 16'h5005, 16'h6006, 16'h7007};
    logic [15:0] bp_a   [6] = '{16'h1234, 16'h8000, 16'h0F0F, 16'hABCD, 16'h4000, 16'hFFFE};
    logic [15:0] bp_b   [6] = '{16'h1111, 16'h8000, 16'h00F1, 16'h5432, 16'h4000, 16'hFFFE};
    logic        bp_cin [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [15:0] bp_sum [6] = '{16'h2345, 16'h0000, 16'h1001, 16'h0000, 16'h8000, 16'hFFFD};
    logic        bp_co  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic        bp_ov  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    int base_count;
    int bp_start;

    initial begin
        bus.in_valid  = 1'b1;
        bus.a         = 16'h0003;
        bus.b         = 16'h0004;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;

        // Reset held for two windows with a valid operand presented.
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset_sum", 32'(bus.sum), 32'd0);
        checkOutput("reset_cout", 32'(bus.cout), 32'd0);
        checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("post_reset_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("post_reset_sum", 32'(bus.sum), 32'd0);
        checkOutput("post_reset_cout", 32'(bus.cout), 32'd0);
        applyStimulus(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);
        idle(6);

        // Carries rippling across segment boundaries, plus overflow corners.
        applyStimulus(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
        applyStimulus(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
        applyStimulus(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        idle(6);

        // Back-to-back throughput.
        base_count = out_count;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(16'(i), 16'(i * 32'h1000), 1'b0, tp_sum[i], 1'b0, 1'b0);
        end
        idle(8);
        checkOutput("throughput_count", 32'(out_count - base_count), 32'd8);

        // Backpressure: out_ready low for three windows while op0 sits at the output.
        base_count = out_count;
        bp_start   = cyc;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    applyStimulus(bp_a[i], bp_b[i], bp_cin[i], bp_sum[i], bp_co[i], bp_ov[i]);
                end
                bus.in_valid = 1'b0;
            end
            begin
                repeat (4) begin
                    @(posedge clk);
                    #1;
                end
                bus.out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    checkOutput("stall_in_ready", 32'(bus.in_ready), 32'd0);
                    checkOutput("stall_out_valid", 32'(bus.out_valid), 32'd1);
                    checkOutput("stall_sum_hold", 32'(bus.sum), 32'h2345);
                    checkOutput("stall_cout_hold", 32'(bus.cout), 32'd0);
                    @(posedge clk);
                    #1;
                end
                bus.out_ready = 1'b1;
                @(negedge clk);
                checkOutput("resume_in_ready", 32'(bus.in_ready), 32'd1);
            end
        join
        idle(8);
        checkOutput("bp_count", 32'(out_count - base_count), 32'd6);
        checkOutput("bp_last_out_window", 32'(last_out_win - bp_start), 32'd12);

        // Reset with three operations in flight: none may ever be emitted.
        applyStimulus(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0);
        applyStimulus(16'h4444, 16'h1111, 1'b1, 16'h5556, 1'b0, 1'b0);
        applyStimulus(16'h8888, 16'h8888, 1'b0, 16'h1110, 1'b1, 1'b1);
        bus.in_valid = 1'b0;
        rst_n        = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            checkOutput("flushed_out_valid", 32'(bus.out_valid), 32'd0);
            @(posedge clk);
            #1;
        end
        base_count = out_count;
        applyStimulus(16'h0F0F, 16'hF0F0, 1'b0, 16'hFFFF, 1'b0, 1'b0);
        idle(8);
        checkOutput("after_reset_count", 32'(out_count - base_count), 32'd1);

        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
